// File: rtl/comp_seq_pkg.sv
// ---------------------------------------------------------------------------
// comp_seq_pkg
// Shared types and defaults for the compressor job sequencer slice.
//   seq_state_t            : sequencer FSM state encoding
//   IMG_ID_W_DEFAULT       : default image index width (8 stored images)
//   TIMEOUT_CYCLES_DEFAULT : default watchdog limit in idle RUN cycles
// ---------------------------------------------------------------------------
package comp_seq_pkg;

    localparam int IMG_ID_W_DEFAULT       = 3;
    localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/comp_job_fifo.sv
// ---------------------------------------------------------------------------
// comp_job_fifo
// Small synchronous FIFO holding queued image-compression job indices.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : enqueue request and data (dropped when full)
//   pop         : dequeue request (ignored when empty)
//   flush       : empties the FIFO; wins over push and pop
//   rdata       : head entry (valid when not empty)
//   full, empty : occupancy flags
//   level       : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module comp_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    // Storage array: written only on an accepted push, no reset needed
    // because level/empty gate every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the
    // level unchanged while both pointers advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/compressor_job_sequencer.sv
// ---------------------------------------------------------------------------
// compressor_job_sequencer
// Pops queued image-compression jobs in order and drives the compressor
// enable / image select, pausing on memory-full and timing out stalled jobs.
// Ports:
//   HCLK, HRESETn           : bus clock, asynchronous active-low reset
//   job_push, job_id        : enqueue strobe and image index
//   job_ready, queue_level  : queue not full, number of queued jobs
//   abort                   : flush queue and stop current job
//   comp_enable, comp_img_sel : registered compressor controls
//   comp_valid_out          : compressor produced a word (feeds watchdog)
//   comp_image_done         : active image fully written (pulse)
//   mem_full                : compressed memory full (level)
//   busy                    : FSM not in IDLE
//   job_done, done_id       : completion pulse and held completed index
//   timeout_err             : watchdog expiry pulse
// Optional build macro COMP_SEQ_STATS_EN adds last_job_cycles[31:0], the
// RUN+PAUSE cycle count of the most recently completed job.
// ---------------------------------------------------------------------------
module compressor_job_sequencer
    import comp_seq_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int IMG_ID_W       = IMG_ID_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               job_push,
    input  logic [IMG_ID_W-1:0]                job_id,
    output logic                               job_ready,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level,
    input  logic                               abort,
    output logic                               comp_enable,
    output logic [IMG_ID_W-1:0]                comp_img_sel,
    input  logic                               comp_valid_out,
    input  logic                               comp_image_done,
    input  logic                               mem_full,
    output logic                               busy,
    output logic                               job_done,
    output logic [IMG_ID_W-1:0]                done_id,
    output logic                               timeout_err
`ifdef COMP_SEQ_STATS_EN
    ,
    output logic [31:0]                        last_job_cycles
`endif
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    seq_state_t          state;
    seq_state_t          state_next;
    logic                q_full;
    logic                q_empty;
    logic                q_pop;
    logic [IMG_ID_W-1:0] head_id;
    logic [15:0]         watchdog;
    logic [15:0]         watchdog_inc;
    logic                wd_expire;

    assign job_ready = !q_full;
    assign busy      = (state != IDLE);
    assign q_pop     = (state == LOAD) && !abort;

    // A push coinciding with abort is discarded by the flush inside the FIFO.
    comp_job_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (IMG_ID_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (job_push),
        .pop   (q_pop),
        .flush (abort),
        .wdata (job_id),
        .rdata (head_id),
        .full  (q_full),
        .empty (q_empty),
        .level (queue_level)
    );

    // The watchdog saturates; expiry is judged on the value it would take
    // this cycle, so exactly TIMEOUT_CYCLES idle RUN cycles trigger ERR.
    assign watchdog_inc = (watchdog == 16'hFFFF) ? watchdog : watchdog + 16'd1;
    assign wd_expire    = !comp_valid_out && (watchdog_inc >= TIMEOUT_LIMIT);

    // Next-state logic. comp_image_done is still honoured while paused, since
    // the image may complete with the memory reporting full; abort overrides.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!q_empty) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN: begin
                if (comp_image_done)  state_next = DONE;
                else if (mem_full)    state_next = PAUSE;
                else if (wd_expire)   state_next = ERR;
            end
            PAUSE: begin
                if (comp_image_done)  state_next = DONE;
                else if (!mem_full)   state_next = RUN;
            end
            DONE:    state_next = q_empty ? IDLE : LOAD;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // State register plus outputs registered from the next state, so
    // comp_enable/job_done/timeout_err line up with the state they describe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            comp_enable  <= 1'b0;
            comp_img_sel <= '0;
            job_done     <= 1'b0;
            done_id      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state       <= state_next;
            comp_enable <= (state_next == RUN);
            job_done    <= (state_next == DONE);
            timeout_err <= (state_next == ERR);
            if (q_pop) begin
                comp_img_sel <= head_id;
            end
            if (state_next == DONE) begin
                done_id <= comp_img_sel;
            end
        end
    end

    // Watchdog: held in PAUSE, counts idle RUN cycles, zero everywhere else
    // (so every fresh RUN entry from LOAD starts at zero).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            watchdog <= '0;
        end else if (abort || (state != RUN && state != PAUSE)) begin
            watchdog <= '0;
        end else if (state == RUN) begin
            watchdog <= comp_valid_out ? 16'd0 : watchdog_inc;
        end
    end

`ifdef COMP_SEQ_STATS_EN
    logic [31:0] stat_cnt;
    logic [31:0] stat_inc;

    assign stat_inc = (stat_cnt == 32'hFFFF_FFFF) ? stat_cnt : stat_cnt + 32'd1;

    // Job length counter: restarts in LOAD, counts RUN and PAUSE cycles and
    // publishes the total (including the finishing cycle) on entry to DONE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stat_cnt        <= '0;
            last_job_cycles <= '0;
        end else begin
            if (state == LOAD) begin
                stat_cnt <= '0;
            end else if (state == RUN || state == PAUSE) begin
                stat_cnt <= stat_inc;
            end
            if (state_next == DONE) begin
                last_job_cycles <= stat_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_compressor_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_compressor_job_sequencer
// Directed self-checking bench for compressor_job_sequencer (watchdog limit
// shortened to 16). Inputs change 1 time unit after each rising edge and
// outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_compressor_job_sequencer;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       job_push;
    logic [2:0] job_id;
    logic       job_ready;
    logic [2:0] queue_level;
    logic       abort;
    logic       comp_enable;
    logic [2:0] comp_img_sel;
    logic       comp_valid_out;
    logic       comp_image_done;
    logic       mem_full;
    logic       busy;
    logic       job_done;
    logic [2:0] done_id;
    logic       timeout_err;
`ifdef COMP_SEQ_STATS_EN
    logic [31:0] last_job_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    compressor_job_sequencer #(
        .QUEUE_DEPTH    (4),
        .IMG_ID_W       (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .job_push        (job_push),
        .job_id          (job_id),
        .job_ready       (job_ready),
        .queue_level     (queue_level),
        .abort           (abort),
        .comp_enable     (comp_enable),
        .comp_img_sel    (comp_img_sel),
        .comp_valid_out  (comp_valid_out),
        .comp_image_done (comp_image_done),
        .mem_full        (mem_full),
        .busy            (busy),
        .job_done        (job_done),
        .done_id         (done_id),
        .timeout_err     (timeout_err)
`ifdef COMP_SEQ_STATS_EN
        ,
        .last_job_cycles (last_job_cycles)
`endif
    );

    // Advance one rising edge and settle just past it.
    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // Reset values while reset is held, before any clock edge.
    task automatic test_reset;
        HRESETn = 1'b0; job_push = 1'b0; job_id = '0; abort = 1'b0;
        comp_valid_out = 1'b0; comp_image_done = 1'b0; mem_full = 1'b0;
        #2;
        total++;
        if ({comp_enable, busy, job_done, timeout_err, job_ready} !== 5'b00001) begin
            bad++; $display("[TB] FAIL reset_flags got=%b exp=00001", {comp_enable, busy, job_done, timeout_err, job_ready});
        end
        total++;
        if ({queue_level, comp_img_sel, done_id} !== 9'd0) begin
            bad++; $display("[TB] FAIL reset_fields got=%h exp=0", {queue_level, comp_img_sel, done_id});
        end
        #10;
        HRESETn = 1'b1;
        tick;
    endtask

    // Single job id 5: 2-edge start latency, done after 10 enabled cycles.
    task automatic test_single_job;
        job_id = 3'd5; job_push = 1'b1;
        tick;
        job_push = 1'b0;
        total++;
        if ({busy, comp_enable, queue_level} !== {2'b00, 3'd1}) begin
            bad++; $display("[TB] FAIL single_queued got=%b exp=00001", {busy, comp_enable, queue_level});
        end
        tick;
        total++;
        if ({busy, comp_enable} !== 2'b10) begin
            bad++; $display("[TB] FAIL single_load got=%b exp=10", {busy, comp_enable});
        end
        tick;
        total++;
        if ({comp_enable, comp_img_sel, queue_level} !== {1'b1, 3'd5, 3'd0}) begin
            bad++; $display("[TB] FAIL single_run got=%b exp=1101000", {comp_enable, comp_img_sel, queue_level});
        end
        for (int i = 1; i < 10; i++) begin
            tick;
            total++;
            if ({comp_enable, job_done} !== 2'b10) begin
                bad++; $display("[TB] FAIL single_running cyc=%0d got=%b exp=10", i, {comp_enable, job_done});
            end
        end
        comp_image_done = 1'b1;
        tick;
        comp_image_done = 1'b0;
        total++;
        if ({job_done, done_id, comp_enable, busy} !== {1'b1, 3'd5, 2'b01}) begin
            bad++; $display("[TB] FAIL single_done got=%b exp=110101", {job_done, done_id, comp_enable, busy});
        end
        tick;
        total++;
        if ({job_done, busy, done_id} !== {2'b00, 3'd5}) begin
            bad++; $display("[TB] FAIL single_idle got=%b exp=00101", {job_done, busy, done_id});
        end
    endtask

    // Job 7 runs while 1,2,3,4,6 are pushed; 6 is dropped, 1..4 follow in order.
    task automatic test_back_to_back;
        logic [2:0] ids [5];
        ids[0] = 3'd1; ids[1] = 3'd2; ids[2] = 3'd3; ids[3] = 3'd4; ids[4] = 3'd6;
        job_id = 3'd7; job_push = 1'b1;
        tick;
        job_push = 1'b0;
        tick;
        tick;
        total++;
        if ({comp_enable, comp_img_sel} !== {1'b1, 3'd7}) begin
            bad++; $display("[TB] FAIL b2b_first_run got=%b exp=1111", {comp_enable, comp_img_sel});
        end
        for (int i = 0; i < 5; i++) begin
            job_id = ids[i]; job_push = 1'b1;
            tick;
            total++;
            if ({queue_level, job_ready} !== {3'((i < 4) ? i + 1 : 4), (i < 3)}) begin
                bad++; $display("[TB] FAIL b2b_fill push=%0d got=%b exp_level=%0d exp_ready=%0d", i, {queue_level, job_ready}, (i < 4) ? i + 1 : 4, (i < 3));
            end
        end
        job_push = 1'b0;
        comp_image_done = 1'b1;
        tick;
        comp_image_done = 1'b0;
        total++;
        if ({job_done, done_id, comp_enable} !== {1'b1, 3'd7, 1'b0}) begin
            bad++; $display("[TB] FAIL b2b_done7 got=%b exp=11110", {job_done, done_id, comp_enable});
        end
        for (int j = 1; j <= 4; j++) begin
            tick;
            total++;
            if ({comp_enable, job_done} !== 2'b00) begin
                bad++; $display("[TB] FAIL b2b_gap job=%0d got=%b exp=00", j, {comp_enable, job_done});
            end
            tick;
            total++;
            if ({comp_enable, comp_img_sel, queue_level} !== {1'b1, 3'(j), 3'(4 - j)}) begin
                bad++; $display("[TB] FAIL b2b_order job=%0d got=%b exp_sel=%0d exp_level=%0d", j, {comp_enable, comp_img_sel, queue_level}, j, 4 - j);
            end
            tick;
            tick;
            comp_image_done = 1'b1;
            tick;
            comp_image_done = 1'b0;
            total++;
            if ({job_done, done_id, comp_enable} !== {1'b1, 3'(j), 1'b0}) begin
                bad++; $display("[TB] FAIL b2b_done job=%0d got=%b exp_id=%0d", j, {job_done, done_id, comp_enable}, j);
            end
        end
        tick;
        total++;
        if ({busy, queue_level} !== 4'b0000) begin
            bad++; $display("[TB] FAIL b2b_drained got=%b exp=0000", {busy, queue_level});
        end
    endtask

    // 5 RUN cycles, mem_full for 20 cycles, 8 more RUN cycles, then done.
    task automatic test_pause;
        job_id = 3'd2; job_push = 1'b1;
        tick;
        job_push = 1'b0;
        tick;
        tick;
        for (int i = 0; i <= 32; i++) begin
            total++;
            if ({comp_enable, timeout_err} !== {(i < 5 || i >= 25), 1'b0}) begin
                bad++; $display("[TB] FAIL pause_enable cyc=%0d got=%b exp=%b0", i, {comp_enable, timeout_err}, (i < 5 || i >= 25));
            end
            mem_full        = (i >= 4 && i <= 23);
            comp_image_done = (i == 32);
            tick;
        end
        mem_full = 1'b0; comp_image_done = 1'b0;
        total++;
        if ({job_done, done_id, timeout_err} !== {1'b1, 3'd2, 1'b0}) begin
            bad++; $display("[TB] FAIL pause_done got=%b exp=10100", {job_done, done_id, timeout_err});
        end
        tick;
    endtask

    // Job 3 times out after 16 idle RUN cycles; queued job 0 then starts and
    // a comp_valid_out restarts its watchdog before it also times out.
    task automatic test_timeout;
        job_id = 3'd3; job_push = 1'b1;
        tick;
        job_id = 3'd0;
        tick;
        job_push = 1'b0;
        tick;
        total++;
        if ({comp_enable, comp_img_sel, queue_level} !== {1'b1, 3'd3, 3'd1}) begin
            bad++; $display("[TB] FAIL to_run got=%b exp=1011001", {comp_enable, comp_img_sel, queue_level});
        end
        for (int k = 1; k <= 16; k++) begin
            tick;
            total++;
            if ({timeout_err, comp_enable, job_done} !== ((k == 16) ? 3'b100 : 3'b010)) begin
                bad++; $display("[TB] FAIL to_wait cyc=%0d got=%b exp=%b", k, {timeout_err, comp_enable, job_done}, (k == 16) ? 3'b100 : 3'b010);
            end
        end
        tick;
        total++;
        if ({busy, timeout_err, queue_level} !== {2'b00, 3'd1}) begin
            bad++; $display("[TB] FAIL to_idle got=%b exp=00001", {busy, timeout_err, queue_level});
        end
        tick;
        tick;
        total++;
        if ({comp_enable, comp_img_sel} !== {1'b1, 3'd0}) begin
            bad++; $display("[TB] FAIL to_second_run got=%b exp=1000", {comp_enable, comp_img_sel});
        end
        for (int k = 1; k <= 10; k++) begin
            tick;
        end
        comp_valid_out = 1'b1;
        tick;
        comp_valid_out = 1'b0;
        total++;
        if ({timeout_err, comp_enable} !== 2'b01) begin
            bad++; $display("[TB] FAIL to_valid got=%b exp=01", {timeout_err, comp_enable});
        end
        for (int k = 1; k <= 16; k++) begin
            tick;
            total++;
            if ({timeout_err, comp_enable} !== ((k == 16) ? 2'b10 : 2'b01)) begin
                bad++; $display("[TB] FAIL to_rewait cyc=%0d got=%b exp=%b", k, {timeout_err, comp_enable}, (k == 16) ? 2'b10 : 2'b01);
            end
        end
        tick;
    endtask

    // Three jobs queued, abort during the first one together with a push.
    task automatic test_abort;
        job_id = 3'd1; job_push = 1'b1;
        tick;
        job_id = 3'd2;
        tick;
        job_id = 3'd3;
        tick;
        job_push = 1'b0;
        total++;
        if ({comp_enable, comp_img_sel, queue_level} !== {1'b1, 3'd1, 3'd2}) begin
            bad++; $display("[TB] FAIL abort_setup got=%b exp=1001010", {comp_enable, comp_img_sel, queue_level});
        end
        tick;
        tick;
        abort = 1'b1; job_push = 1'b1; job_id = 3'd5;
        tick;
        abort = 1'b0; job_push = 1'b0;
        total++;
        if ({comp_enable, busy, queue_level, job_done, timeout_err, job_ready} !== 8'b00000001) begin
            bad++; $display("[TB] FAIL abort_flush got=%b exp=00000001", {comp_enable, busy, queue_level, job_done, timeout_err, job_ready});
        end
        comp_image_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            comp_image_done = 1'b0;
            total++;
            if ({busy, queue_level, job_done, timeout_err} !== 6'b000000) begin
                bad++; $display("[TB] FAIL abort_quiet cyc=%0d got=%b exp=000000", k, {busy, queue_level, job_done, timeout_err});
            end
        end
    endtask

`ifdef COMP_SEQ_STATS_EN
    // 30 RUN cycles plus 5 PAUSE cycles give a job length of 35.
    task automatic test_stats;
        job_id = 3'd4; job_push = 1'b1;
        tick;
        job_push = 1'b0;
        tick;
        tick;
        comp_valid_out = 1'b1;
        for (int i = 0; i <= 34; i++) begin
            mem_full        = (i >= 9 && i <= 13);
            comp_image_done = (i == 34);
            tick;
        end
        mem_full = 1'b0; comp_image_done = 1'b0; comp_valid_out = 1'b0;
        total++;
        if ({job_done, last_job_cycles} !== {1'b1, 32'd35}) begin
            bad++; $display("[TB] FAIL stats_cycles got_done=%b got=%0d exp=35", job_done, last_job_cycles);
        end
        tick;
    endtask
`endif

    // Reset asserted between edges while a job runs forces reset values at once.
    task automatic test_async_reset;
        job_id = 3'd6; job_push = 1'b1;
        tick;
        job_id = 3'd5;
        tick;
        job_push = 1'b0;
        tick;
        total++;
        if ({comp_enable, comp_img_sel, queue_level} !== {1'b1, 3'd6, 3'd1}) begin
            bad++; $display("[TB] FAIL arst_setup got=%b exp=1110001", {comp_enable, comp_img_sel, queue_level});
        end
        #2;
        HRESETn = 1'b0;
        #1;
        total++;
        if ({comp_enable, busy, queue_level, job_ready, comp_img_sel, done_id} !== {5'b00000, 1'b1, 6'd0}) begin
            bad++; $display("[TB] FAIL arst_values got=%b exp=000001000000", {comp_enable, busy, queue_level, job_ready, comp_img_sel, done_id});
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick;
        total++;
        if ({busy, queue_level} !== 4'b0000) begin
            bad++; $display("[TB] FAIL arst_after got=%b exp=0000", {busy, queue_level});
        end
    endtask

    initial begin
        test_reset;
        test_single_job;
        test_back_to_back;
        test_pause;
        test_timeout;
        test_abort;
`ifdef COMP_SEQ_STATS_EN
        test_stats;
`endif
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compressor_job_sequencer.md
Name: compressor_job_sequencer

Overview:
- Sequences the image compressor datapath. Software queues image-compression jobs (image index 0-7) through the register file; this block pops them in order and drives the compressor enable and image select.
- It pauses the compressor while the compressed-output memory reports full, detects stalled jobs with a watchdog, and reports per-job completion and timeout.
- Sits between the AHB register file and the compression top and compression memory, on the bus clock domain.

Parameters:
- QUEUE_DEPTH, 4: job FIFO entries. Power of two, at least 2.
- IMG_ID_W, 3: image index width, selecting one of 8 stored images.
- TIMEOUT_CYCLES, 65535: idle RUN cycles without output before a timeout. At least 1, fits in 16 bits.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  asynchronous active-low reset.
- job_push  in  1  enqueue request from the register file (one-cycle strobe).
- job_id  in  IMG_ID_W  image index sampled with job_push.
- job_ready  out  1  queue not full.
- queue_level  out  $clog2(QUEUE_DEPTH+1)  number of queued jobs.
- abort  in  1  flushes the queue and stops the current job.
- comp_enable  out  1  compressor run enable (registered).
- comp_img_sel  out  IMG_ID_W  image index of the active job (registered).
- comp_valid_out  in  1  compressor produced an output word this cycle.
- comp_image_done  in  1  compressed image fully written to memory (pulse).
- mem_full  in  1  compressed memory full (level).
- busy  out  1  FSM is not in IDLE.
- job_done  out  1  one-cycle pulse when a job completes.
- done_id  out  IMG_ID_W  index of the completed job; held until the next completion.
- timeout_err  out  1  one-cycle pulse when a job times out.

Behaviour:
- Reset values: all outputs 0, except job_ready=1. Queue is empty, FSM is in IDLE, watchdog is 0.
- Queue behaviour:
  - A push is accepted iff job_push && job_ready.
  - A push while full is dropped silently, and queue_level is unchanged.
  - A push and a pop in the same cycle are both honoured when not full; queue_level is unchanged.
  - Read and write pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE, ERR.
  - IDLE -> LOAD when the queue is non-empty.
  - LOAD: pops the head entry and latches it into comp_img_sel, then goes to RUN.
  - RUN: comp_enable=1.
    - -> DONE on comp_image_done.
    - Otherwise -> PAUSE on mem_full.
    - Otherwise -> ERR when the watchdog reaches TIMEOUT_CYCLES.
  - PAUSE: comp_enable=0; the watchdog is frozen. -> RUN when mem_full=0.
  - DONE: job_done=1 and done_id<=comp_img_sel. -> LOAD if the queue is non-empty, else -> IDLE.
  - ERR: timeout_err=1, comp_enable=0. -> IDLE. The queue is kept; the next job starts from IDLE.
- Priority in RUN: comp_image_done > mem_full > timeout.
- Latency: a push at edge E0 gives IDLE->LOAD at E1 and LOAD->RUN at E2. comp_enable is high after E2.
- Back-to-back jobs: DONE->LOAD->RUN gives exactly 2 cycles with comp_enable=0 between jobs.
- Watchdog: cleared on entry to RUN and on every comp_valid_out; increments in RUN otherwise; saturates.
- abort: highest priority, any state -> IDLE at the next edge.
  - Queue is flushed and the watchdog is cleared.
  - No job_done or timeout_err is produced.
  - A push in the same cycle as abort is discarded.
- Ignored inputs: comp_image_done outside RUN/PAUSE; comp_valid_out outside RUN.
- Reset mid-operation forces the reset values immediately (asynchronous).

Optional Feature:
- Macro: COMP_SEQ_STATS_EN.
- When defined:
  - Adds output last_job_cycles [31:0], reset 0.
  - An internal counter clears in LOAD and increments in RUN and PAUSE, saturating at 32'hFFFF_FFFF.
  - The count is copied to last_job_cycles on entry to DONE; it is unchanged on ERR or abort.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package comp_seq_pkg holds:
  - the seq_state_t enum (IDLE, LOAD, RUN, PAUSE, DONE, ERR);
  - the IMG_ID_W default;
  - the default TIMEOUT_CYCLES.
- One sub-module, comp_job_fifo: synchronous FIFO with push/pop/flush, full/empty and level outputs.
- FSM, watchdog and stats counter stay in the top module.

Test Plan:
1. Push id=5, then comp_image_done 10 cycles after comp_enable rises:
   - comp_enable rises 2 edges after the push, with comp_img_sel=5.
   - job_done pulses once with done_id=5.
   - busy drops one cycle later.
2. Push ids 1,2,3,4,6 back-to-back with no pops:
   - queue_level reaches 4 and job_ready goes 0.
   - id 6 is dropped.
   - The jobs then execute in order 1,2,3,4, with a 2-cycle enable gap between jobs.
3. Drive mem_full=1 for 20 cycles during RUN:
   - comp_enable=0 throughout and the watchdog is frozen.
   - RUN resumes on the cycle after mem_full=0, and no timeout occurs.
4. TIMEOUT_CYCLES=16, job started, no comp_valid_out:
   - timeout_err pulses 16 cycles after RUN entry.
   - comp_enable drops and FSM returns to IDLE.
   - A queued second job then starts.
5. Three jobs queued, abort during RUN of the first:
   - comp_enable=0 next cycle and queue_level=0.
   - No job_done or timeout_err.
   - A push in the same cycle as abort is ignored.
6. With COMP_SEQ_STATS_EN defined: a job runs 30 RUN cycles plus 5 PAUSE cycles -> last_job_cycles=35 after job_done.
